fir_band_scheduler: RTL and testbench
=====================================

# fir_band_scheduler

Sequencer that time-shares the single FIR/moving-average datapath across `NUM_BANDS` frequency bands of the audio visualizer. For each accepted audio sample it drives the datapath's phase handshakes (load sample, shift, load coefficients, multiply, send, reset signals) once per band. It captures each band's result and reports it with a band index for the display path. It sits between the sample source and the shared datapath, replacing the push-button-stepped control used on the test bench.

## Interface
- `NUM_BANDS`, 8: bands sequenced per sample, 2..8.
- `DATA_W`, 64: datapath sample/result width.
- `TIMEOUT`, 255: max cycles to wait for any done; 0 disables.

- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `sample_valid`  in  1  new sample offered
- `sample_in`  in  16  signed audio sample
- `sample_ready`  out  1  high only in IDLE
- `ld_newsample` / `newsampleloaded`  out / in  1  load-sample phase handshake
- `shift` / `shiftdone`  out / in  1  delay-line shift phase
- `ld_values` / `loaddone`  out / in  1  coefficient-load phase
- `multiply` / `multiplydone`  out / in  1  MAC phase
- `send` / `sentdone`  out / in  1  result-output phase
- `rsignals` / `rsignalsdone`  out / in  1  datapath reset-signals phase
- `band_sel`  out  3  coefficient bank for the current band
- `dp_sample`  out  DATA_W  sign-extended latched sample
- `dp_result`  in  DATA_W  datapath result, valid once `sentdone` is seen
- `result_out`  out  DATA_W  captured band result
- `result_band`  out  3  band index of `result_out`
- `result_valid`  out  1  one-cycle strobe
- `frame_done`  out  1  one-cycle strobe, all bands finished
- `overrun`  out  1  sticky, sample dropped while busy
- `timeout_err`  out  1  sticky, handshake timed out

## Operation
- States: IDLE, LDSAMPLE, SHIFT, LDVAL, MULT, SEND, STORE, RSIG.
- IDLE: `sample_ready`=1. On `sample_valid`, latch `dp_sample` = sign-extended `sample_in`, set band=0, go to LDSAMPLE.
- The shared-delay-line phases run once per frame: LDSAMPLE (`ld_newsample`) then SHIFT (`shift`), then go to LDVAL.
- Per-band loop:
  - LDVAL (`ld_values`) -> MULT (`multiply`) -> SEND (`send`) -> STORE -> RSIG (`rsignals`).
  - RSIG exit: if band==NUM_BANDS-1, go to IDLE and pulse `frame_done`; else band+1, go to LDVAL.
- Handshake states are Moore:
  - The request is high for every cycle in the state.
  - Advance on the edge where the matching done is sampled high; the request drops on that edge.
  - At most one request is high at any time.
- STORE: one cycle, no request. On exit, register `result_out`=`dp_result` and `result_band`=band, and pulse `result_valid`.
- `band_sel` = band, held constant from LDVAL through RSIG.
- `dp_sample` is held for the whole frame.
- `sample_valid` outside IDLE: the sample is dropped, `overrun` is set, and the current frame is unaffected.
- Timeout: a per-state counter clears on state entry. If it reaches TIMEOUT in a handshake state without done:
  - set `timeout_err`;
  - drop all requests;
  - go to IDLE with no `frame_done`, and no `result_valid` for that band.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, immediate, including mid-frame):
  - state IDLE, band 0;
  - all requests 0;
  - `sample_ready`=1;
  - all other outputs 0.
- Minimum per-state latency is 1 cycle. With every done tied high and acceptance at edge E0:
  - LDSAMPLE runs from E0, SHIFT from E1.
  - Band b: LDVAL from E2+5b, STORE from E5+5b.
  - `result_valid` for band b is high in the cycle after edge E6+5b.
  - For NUM_BANDS=8, `frame_done` and `sample_ready` are high after E42.
- Frame cost is 2+5·NUM_BANDS cycles plus any done-wait cycles.
- A done asserted while its request is low is ignored.
- `sample_valid` on the same edge as returning to IDLE is not accepted; it is accepted on the next edge.

## Test plan
- All dones tied high, NUM_BANDS=8, `sample_in`=16'h8001 -> `dp_sample`=64'hFFFF_FFFF_FFFF_8001. `result_valid` pulses 8 times with `result_band` 0..7 at E6,E11,…,E41. `frame_done` pulses after E42.
- `multiplydone` delayed 10 cycles per band -> `multiply` stays high exactly 11 cycles each time, `band_sel` is stable, and `frame_done` comes after E42+80.
- `sample_valid` pulsed during band 3 -> `overrun`=1, and the frame completes with bands 4..7 unchanged.
- `sentdone` held low, TIMEOUT=20 -> `send` drops after 20 cycles, `timeout_err`=1, return to IDLE with no `frame_done`; the next sample runs normally.
- `resetn` asserted during MULT of band 5 -> all requests 0 immediately, sticky flags cleared, and the next frame restarts at band 0.
- `loaddone` high while in SHIFT -> ignored, with no state skip.

Source files
------------

// File: rtl/fir_band_scheduler.sv
// Sequencer that time-shares one FIR/moving-average datapath across NUM_BANDS bands:
// per accepted sample it walks the datapath phase handshakes once per band and reports each result.
module fir_band_scheduler #(
  parameter int unsigned NUM_BANDS = 8,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_valid,
  input  logic [15:0]       sample_in,
  output logic              sample_ready,
  output logic              ld_newsample,
  input  logic              newsampleloaded,
  output logic              shift,
  input  logic              shiftdone,
  output logic              ld_values,
  input  logic              loaddone,
  output logic              multiply,
  input  logic              multiplydone,
  output logic              send,
  input  logic              sentdone,
  output logic              rsignals,
  input  logic              rsignalsdone,
  output logic [2:0]        band_sel,
  output logic [DATA_W-1:0] dp_sample,
  input  logic [DATA_W-1:0] dp_result,
  output logic [DATA_W-1:0] result_out,
  output logic [2:0]        result_band,
  output logic              result_valid,
  output logic              frame_done,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int unsigned BAND_W  = 3;
  localparam int unsigned REQ_W   = 6;
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);

  // Request vector bit positions
  localparam int unsigned R_LDS = 0;
  localparam int unsigned R_SHF = 1;
  localparam int unsigned R_LDV = 2;
  localparam int unsigned R_MUL = 3;
  localparam int unsigned R_SND = 4;
  localparam int unsigned R_RSG = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_LDSAMPLE, S_SHIFT, S_LDVAL, S_MULT, S_SEND, S_STORE, S_RSIG
  } state_e;

  state_e              state_q, state_d;
  logic [BAND_W-1:0]   band_q, band_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [BAND_W-1:0]   rband_q, rband_d;
  logic                rvalid_q, rvalid_d;
  logic                fdone_q, fdone_d;
  logic                overrun_q, overrun_d;
  logic                tout_q, tout_d;
  logic [REQ_W-1:0]    req_q, req_d;
  logic                ready_q, ready_d;
  logic                done_c;
  logic                hs_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      band_q    <= '0;
      cnt_q     <= '0;
      sample_q  <= '0;
      result_q  <= '0;
      rband_q   <= '0;
      rvalid_q  <= 1'b0;
      fdone_q   <= 1'b0;
      overrun_q <= 1'b0;
      tout_q    <= 1'b0;
      req_q     <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      band_q    <= band_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      result_q  <= result_d;
      rband_q   <= rband_d;
      rvalid_q  <= rvalid_d;
      fdone_q   <= fdone_d;
      overrun_q <= overrun_d;
      tout_q    <= tout_d;
      req_q     <= req_d;
      ready_q   <= ready_d;
    end
  end

  // Next state, per-state timeout counter and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    band_d    = band_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    result_d  = result_q;
    rband_d   = rband_q;
    rvalid_d  = 1'b0;
    fdone_d   = 1'b0;
    overrun_d = overrun_q;
    tout_d    = tout_q;
    req_d     = '0;
    ready_d   = 1'b0;
    done_c    = 1'b0;
    hs_c      = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        hs_c = 1'b0;
        if (sample_valid) begin
          sample_d = DATA_W'($signed(sample_in));
          band_d   = '0;
          state_d  = S_LDSAMPLE;
        end
      end
      S_LDSAMPLE: begin
        done_c = newsampleloaded;
        if (done_c) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        done_c = shiftdone;
        if (done_c) state_d = S_LDVAL;
      end
      S_LDVAL: begin
        done_c = loaddone;
        if (done_c) state_d = S_MULT;
      end
      S_MULT: begin
        done_c = multiplydone;
        if (done_c) state_d = S_SEND;
      end
      S_SEND: begin
        done_c = sentdone;
        if (done_c) state_d = S_STORE;
      end
      S_STORE: begin
        hs_c     = 1'b0;
        result_d = dp_result;
        rband_d  = band_q;
        rvalid_d = 1'b1;
        state_d  = S_RSIG;
      end
      S_RSIG: begin
        done_c = rsignalsdone;
        if (done_c) begin
          if (band_q == LAST_BAND) begin
            band_d  = '0;
            fdone_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            band_d  = band_q + BAND_W'(1);
            state_d = S_LDVAL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled handshake abandons the frame; done on the same edge still wins
    if (hs_c && !done_c && (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
      tout_d  = 1'b1;
      band_d  = '0;
      state_d = S_IDLE;
    end

    if (sample_valid && (state_q != S_IDLE)) overrun_d = 1'b1;

    if ((state_d != state_q) || (TIMEOUT == 0)) cnt_d = '0;
    else if (cnt_q != CNT_W'(TO_LAST))          cnt_d = cnt_q + CNT_W'(1);

    unique case (state_d)
      S_IDLE:     ready_d      = 1'b1;
      S_LDSAMPLE: req_d[R_LDS] = 1'b1;
      S_SHIFT:    req_d[R_SHF] = 1'b1;
      S_LDVAL:    req_d[R_LDV] = 1'b1;
      S_MULT:     req_d[R_MUL] = 1'b1;
      S_SEND:     req_d[R_SND] = 1'b1;
      S_RSIG:     req_d[R_RSG] = 1'b1;
      default:    req_d        = '0;
    endcase
  end

  assign sample_ready = ready_q;
  assign ld_newsample = req_q[R_LDS];
  assign shift        = req_q[R_SHF];
  assign ld_values    = req_q[R_LDV];
  assign multiply     = req_q[R_MUL];
  assign send         = req_q[R_SND];
  assign rsignals     = req_q[R_RSG];
  assign band_sel     = band_q;
  assign dp_sample    = sample_q;
  assign result_out   = result_q;
  assign result_band  = rband_q;
  assign result_valid = rvalid_q;
  assign frame_done   = fdone_q;
  assign overrun      = overrun_q;
  assign timeout_err  = tout_q;

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Bench for fir_band_scheduler: a delay-programmable datapath responder plus a cycle-budget
// model of the frame schedule, checked against result/frame events seen on the outputs.
module tb_fir_band_scheduler;

  localparam int unsigned NB = 8;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 20;

  logic          clk = 1'b0;
  logic          resetn;
  logic          sample_valid;
  logic [15:0]   sample_in;
  logic          sample_ready;
  logic          ld_newsample, shift, ld_values, multiply, send, rsignals;
  logic          newsampleloaded, shiftdone, loaddone, multiplydone, sentdone, rsignalsdone;
  logic [2:0]    band_sel;
  logic [DW-1:0] dp_sample, dp_result, result_out;
  logic [2:0]    result_band;
  logic          result_valid, frame_done, overrun, timeout_err;

  always #5 clk = ~clk;

  fir_band_scheduler #(.NUM_BANDS(NB), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_ready(sample_ready),
    .ld_newsample(ld_newsample), .newsampleloaded(newsampleloaded),
    .shift(shift), .shiftdone(shiftdone),
    .ld_values(ld_values), .loaddone(loaddone),
    .multiply(multiply), .multiplydone(multiplydone),
    .send(send), .sentdone(sentdone),
    .rsignals(rsignals), .rsignalsdone(rsignalsdone),
    .band_sel(band_sel), .dp_sample(dp_sample), .dp_result(dp_result),
    .result_out(result_out), .result_band(result_band), .result_valid(result_valid),
    .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  // Datapath responder: channel i answers after dly[i] wait cycles, or never if hold_lo[i]
  int            dly [6] = '{0, 0, 0, 0, 0, 0};
  bit            hold_lo [6] = '{0, 0, 0, 0, 0, 0};
  bit            spur_ld = 1'b0;
  int            wc [6] = '{0, 0, 0, 0, 0, 0};
  logic [5:0]    req, dn;
  logic [DW-1:0] res_tab [8];

  assign req = {rsignals, send, multiply, ld_values, shift, ld_newsample};
  always_comb for (int i = 0; i < 6; i++) dn[i] = req[i] && !hold_lo[i] && (wc[i] >= dly[i]);
  always @(posedge clk) for (int i = 0; i < 6; i++) wc[i] <= req[i] ? wc[i] + 1 : 0;

  assign newsampleloaded = dn[0];
  assign shiftdone       = dn[1];
  assign loaddone        = dn[2] | (spur_ld & shift);
  assign multiplydone    = dn[3];
  assign sentdone        = dn[4];
  assign rsignalsdone    = dn[5];
  assign dp_result       = res_tab[band_sel];

  // Output monitor
  int            cyc = 0;
  int            rv_cyc[$], rv_band[$], fd_cyc[$];
  logic [DW-1:0] rv_val[$];
  int            mul_len[$], send_len[$], shift_len[$];
  int            mrun = 0, srun = 0, hrun = 0;
  int            overlap_err = 0, bsel_err = 0;
  logic [2:0]    bsel_lat = '0;
  logic          ldv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (result_valid) begin
      rv_cyc.push_back(cyc); rv_band.push_back(int'(result_band)); rv_val.push_back(result_out);
    end
    if (frame_done) fd_cyc.push_back(cyc);
    if ($countones(req) > 1) overlap_err++;
    if (multiply) mrun++; else if (mrun != 0) begin mul_len.push_back(mrun); mrun = 0; end
    if (send) srun++; else if (srun != 0) begin send_len.push_back(srun); srun = 0; end
    if (shift) hrun++; else if (hrun != 0) begin shift_len.push_back(hrun); hrun = 0; end
    if (ld_values && !ldv_prev) bsel_lat = band_sel;
    else if ((multiply || send || rsignals) && band_sel != bsel_lat) bsel_err++;
    ldv_prev = ld_values;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int exp_rv [8];
  int exp_fd;

  // Frame schedule from the per-state cycle budget: each handshake costs 1 + wait cycles
  function automatic void build_model();
    int t;
    t = 2 + dly[0] + dly[1];
    for (int b = 0; b < int'(NB); b++) begin
      t += 3 + dly[2] + dly[3] + dly[4];
      exp_rv[b] = t + 1;
      t += 2 + dly[5];
    end
    exp_fd = t;
  endfunction

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(negedge clk); #1; end
  endtask

  task automatic accept(input logic [15:0] s, output int e0);
    @(negedge clk);
    sample_valid = 1'b1; sample_in = s;
    @(posedge clk); #1;
    e0 = cyc;
    sample_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int e0, input int rv0, input int fd0,
                             input logic [15:0] s);
    int lim;
    logic [DW-1:0] want;
    lim = 2000;
    while (fd_cyc.size() == fd0 && lim > 0) begin @(negedge clk); #1; lim--; end
    n_tests++;
    if (fd_cyc.size() == fd0) begin
      n_fail++; $display("FAIL %s frame_done: none within bound", tag); return;
    end
    build_model();
    n_tests++;
    if (fd_cyc[fd0] - e0 !== exp_fd) begin
      n_fail++; $display("FAIL %s frame_done time: got +%0d want +%0d", tag, fd_cyc[fd0] - e0, exp_fd);
    end
    n_tests++;
    if (rv_cyc.size() - rv0 !== int'(NB)) begin
      n_fail++; $display("FAIL %s result count: got %0d want %0d", tag, rv_cyc.size() - rv0, NB);
    end
    for (int b = 0; b < int'(NB); b++) begin
      n_tests++;
      if (rv0 + b >= rv_cyc.size()) begin
        n_fail++; $display("FAIL %s band%0d result: missing", tag, b);
      end else if (rv_band[rv0+b] !== b || rv_val[rv0+b] !== res_tab[b] ||
                   rv_cyc[rv0+b] - e0 !== exp_rv[b]) begin
        n_fail++;
        $display("FAIL %s band%0d result: got band=%0d val=%h at +%0d, want band=%0d val=%h at +%0d",
                 tag, b, rv_band[rv0+b], rv_val[rv0+b], rv_cyc[rv0+b] - e0, b, res_tab[b], exp_rv[b]);
      end
    end
    want = DW'(longint'(shortint'(s)));
    n_tests++;
    if (dp_sample !== want) begin
      n_fail++; $display("FAIL %s dp_sample: got %h want %h", tag, dp_sample, want);
    end
    n_tests++;
    if (sample_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready after frame: got %b want 1", tag, sample_ready);
    end
  endtask

  task automatic fill_results();
    for (int b = 0; b < 8; b++) res_tab[b] = {$urandom(), $urandom()};
  endtask

  task automatic test_reset();
    resetn = 1'b1; sample_valid = 1'b0; sample_in = '0;
    fill_results();
    #12 resetn = 1'b0;
    #1;
    n_tests++;
    if (sample_ready !== 1'b1 || req !== 6'b0) begin
      n_fail++; $display("FAIL reset ready/req: got %b/%b want 1/000000", sample_ready, req);
    end
    n_tests++;
    if ({result_valid, frame_done, overrun, timeout_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset strobes/flags: got %b want 0000",
                         {result_valid, frame_done, overrun, timeout_err});
    end
    n_tests++;
    if (dp_sample !== '0 || result_out !== '0 || band_sel !== 3'd0 || result_band !== 3'd0) begin
      n_fail++; $display("FAIL reset data: got %h %h %0d %0d want zeros", dp_sample, result_out,
                         band_sel, result_band);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_high();
    int e0, rv0, fd0;
    fill_results();
    rv0 = rv_cyc.size(); fd0 = fd_cyc.size();
    accept(16'h8001, e0);
    n_tests++;
    if (dp_sample !== 64'hFFFF_FFFF_FFFF_8001) begin
      n_fail++; $display("FAIL all_high dp_sample: got %h want FFFFFFFFFFFF8001", dp_sample);
    end
    check_frame("all_high", e0, rv0, fd0, 16'h8001);
  endtask

  task automatic test_mult_delay();
    int e0, rv0, fd0, m0;
    fill_results();
    dly[3] = 10;
    rv0 = rv_cyc.size(); fd0 = fd_cyc.size(); m0 = mul_len.size();
    accept(16'h1234, e0);
    check_frame("mult_delay", e0, rv0, fd0, 16'h1234);
    n_tests++;
    if (fd_cyc.size() > fd0 && fd_cyc[fd0] - e0 !== 42 + 80) begin
      n_fail++; $display("FAIL mult_delay frame length: got +%0d want +122", fd_cyc[fd0] - e0);
    end
    for (int b = 0; b < int'(NB); b++) begin
      n_tests++;
      if (m0 + b >= mul_len.size() || mul_len[m0+b] !== 11) begin
        n_fail++; $display("FAIL mult_delay multiply width band%0d: got %0d want 11", b,
                           (m0 + b < mul_len.size()) ? mul_len[m0+b] : -1);
      end
    end
    dly[3] = 0;
  endtask

  task automatic test_overrun();
    int e0, rv0, fd0;
    fill_results();
    rv0 = rv_cyc.size(); fd0 = fd_cyc.size();
    accept(16'h7F00, e0);
    wait_cyc(e0 + 2 + 5 * 3 + 1);
    sample_valid = 1'b1; sample_in = 16'h0BAD;
    @(negedge clk); #1;
    sample_valid = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun flag: got %b want 1", overrun);
    end
    check_frame("overrun", e0, rv0, fd0, 16'h7F00);
  endtask

  task automatic test_timeout();
    int e0, rv0, fd0, s0, lim;
    fill_results();
    hold_lo[4] = 1'b1;
    rv0 = rv_cyc.size(); fd0 = fd_cyc.size(); s0 = send_len.size();
    accept(16'h0042, e0);
    lim = 200;
    while (timeout_err !== 1'b1 && lim > 0) begin @(negedge clk); #1; lim--; end
    n_tests++;
    if (timeout_err !== 1'b1 || cyc - e0 !== 4 + int'(TO)) begin
      n_fail++; $display("FAIL timeout flag: got %b at +%0d want 1 at +%0d", timeout_err, cyc - e0,
                         4 + TO);
    end
    n_tests++;
    if (sample_ready !== 1'b1 || req !== 6'b0) begin
      n_fail++; $display("FAIL timeout idle: got ready=%b req=%b want 1/000000", sample_ready, req);
    end
    repeat (5) @(negedge clk);
    #1;
    n_tests++;
    if (s0 >= send_len.size() || send_len[s0] !== int'(TO)) begin
      n_fail++; $display("FAIL timeout send width: got %0d want %0d",
                         (s0 < send_len.size()) ? send_len[s0] : -1, TO);
    end
    n_tests++;
    if (fd_cyc.size() !== fd0 || rv_cyc.size() !== rv0) begin
      n_fail++; $display("FAIL timeout strobes: got %0d done %0d results want 0/0",
                         fd_cyc.size() - fd0, rv_cyc.size() - rv0);
    end
    hold_lo[4] = 1'b0;
    accept(16'hFFFF, e0);
    check_frame("after_timeout", e0, rv0, fd0, 16'hFFFF);
  endtask

  task automatic test_reset_mid();
    int e0, rv0, fd0;
    fill_results();
    accept(16'h5555, e0);
    wait_cyc(e0 + 3 + 5 * 5);
    n_tests++;
    if (multiply !== 1'b1 || band_sel !== 3'd5) begin
      n_fail++; $display("FAIL reset_mid position: got mult=%b band=%0d want 1/5", multiply, band_sel);
    end
    resetn = 1'b0;
    #1;
    n_tests++;
    if (req !== 6'b0 || sample_ready !== 1'b1 || band_sel !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid outputs: got req=%b ready=%b band=%0d want 000000/1/0",
                         req, sample_ready, band_sel);
    end
    n_tests++;
    if (overrun !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid sticky: got %b%b want 00", overrun, timeout_err);
    end
    @(negedge clk);
    resetn = 1'b1;
    rv0 = rv_cyc.size(); fd0 = fd_cyc.size();
    accept(16'hA5A5, e0);
    check_frame("after_reset", e0, rv0, fd0, 16'hA5A5);
  endtask

  task automatic test_spurious_done();
    int e0, rv0, fd0, h0;
    fill_results();
    dly[1] = 3; spur_ld = 1'b1;
    rv0 = rv_cyc.size(); fd0 = fd_cyc.size(); h0 = shift_len.size();
    accept(16'h00FF, e0);
    check_frame("spurious", e0, rv0, fd0, 16'h00FF);
    n_tests++;
    if (h0 >= shift_len.size() || shift_len[h0] !== 4) begin
      n_fail++; $display("FAIL spurious shift width: got %0d want 4",
                         (h0 < shift_len.size()) ? shift_len[h0] : -1);
    end
    dly[1] = 0; spur_ld = 1'b0;
  endtask

  task automatic test_back_to_back();
    int e0, e1, rv0, fd0;
    fill_results();
    accept(16'h1111, e0);
    sample_valid = 1'b1; sample_in = 16'h2222;
    wait_cyc(e0 + 42);
    n_tests++;
    if (sample_ready !== 1'b1 || ld_newsample !== 1'b0 || dp_sample !== 64'h1111) begin
      n_fail++; $display("FAIL b2b return edge: got ready=%b lds=%b dps=%h want 1/0/1111",
                         sample_ready, ld_newsample, dp_sample);
    end
    rv0 = rv_cyc.size(); fd0 = fd_cyc.size();
    wait_cyc(e0 + 43);
    e1 = cyc;
    sample_valid = 1'b0;
    n_tests++;
    if (ld_newsample !== 1'b1 || sample_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b accept edge: got lds=%b ready=%b want 1/0", ld_newsample,
                         sample_ready);
    end
    check_frame("b2b", e1, rv0, fd0, 16'h2222);
  endtask

  task automatic test_random();
    int e0, rv0, fd0;
    logic [15:0] s;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 6; i++) dly[i] = int'($urandom_range(0, 4));
      fill_results();
      s = 16'($urandom());
      rv0 = rv_cyc.size(); fd0 = fd_cyc.size();
      accept(s, e0);
      check_frame("random", e0, rv0, fd0, s);
    end
    for (int i = 0; i < 6; i++) dly[i] = 0;
  endtask

  initial begin
    test_reset();
    test_all_high();
    test_mult_delay();
    test_overrun();
    test_timeout();
    test_reset_mid();
    test_spurious_done();
    test_back_to_back();
    test_random();
    n_tests++;
    if (overlap_err !== 0 || bsel_err !== 0) begin
      n_fail++; $display("FAIL request overlap/band_sel hold: got %0d/%0d want 0/0", overlap_err,
                         bsel_err);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
